// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_LOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_CMD_LINE1     = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2     = 8'hC0;
  localparam logic [7:0] LCD_CMD_WAKE      = 8'h30;
  localparam logic [7:0] LCD_CMD_DISP_OFF  = 8'h08;

  localparam int INIT_LEN = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-up command sequence for 8-bit, 2-line operation.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] idx_i,
  output logic [7:0] cmd_o
);

  always_comb begin
    cmd_o = LCD_CMD_WAKE;
    case (idx_i)
      3'd0, 3'd1, 3'd2: cmd_o = LCD_CMD_WAKE;
      3'd3:             cmd_o = LCD_CMD_FUNC_8B2L;
      3'd4:             cmd_o = LCD_CMD_DISP_OFF;
      3'd5:             cmd_o = LCD_CMD_CLEAR;
      3'd6:             cmd_o = LCD_CMD_ENTRY_INC;
      default:          cmd_o = LCD_CMD_DISP_ON;
    endcase
  end

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 8-bit write engine: autonomous init, then valid/ready byte writes.
// Define LCD_LINE_WRAP_EN to insert line-2 / line-1 address commands every 16 chars.
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 4,
  parameter int EN_CYC         = 25,
  parameter int HOLD_CYC       = 4,
  parameter int WAIT_CYC       = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done
);

  localparam int MAXC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(EN_CYC, HOLD_CYC)),
                             max2(WAIT_CYC, CLEAR_WAIT_CYC));
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] L_PWR   = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] L_EN    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] L_WAIT  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] L_CLR   = CW'(CLEAR_WAIT_CYC - 1);

  lcd_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            done_q, done_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            en_q;
  logic [7:0]      rom_cmd;
  logic            cnt_zero;

`ifdef LCD_LINE_WRAP_EN
  logic [4:0]      col_q, col_d;
  logic            line1_q, line1_d;   // 32 chars written, next char goes back to line 1
  logic            pend_q, pend_d;     // a data byte waits behind an inserted command
  logic [7:0]      pdata_q, pdata_d;
`endif

  lcd_init_rom u_rom (
    .idx_i (idx_q),
    .cmd_o (rom_cmd)
  );

  assign cnt_zero  = (cnt_q == '0);
  assign in_ready  = (state_q == ST_IDLE) && done_q;
  assign lcd_en    = en_q;
  assign lcd_on    = 1'b1;
  assign lcd_rw    = 1'b0;
  assign lcd_rs    = rs_q;
  assign lcd_data  = data_q;
  assign init_done = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? '0 : cnt_q - CW'(1);
    idx_d   = idx_q;
    done_d  = done_q;
    rs_d    = rs_q;
    data_d  = data_q;
`ifdef LCD_LINE_WRAP_EN
    col_d   = col_q;
    line1_d = line1_q;
    pend_d  = pend_q;
    pdata_d = pdata_q;
`endif
    case (state_q)
      ST_POWERUP: if (cnt_zero) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!done_q) begin
          rs_d   = 1'b0;
          data_d = rom_cmd;
        end
`ifdef LCD_LINE_WRAP_EN
        else if (pend_q) begin
          rs_d   = 1'b1;
          data_d = pdata_q;
          pend_d = 1'b0;
        end
`endif
        state_d = ST_SETUP;
        cnt_d   = L_SETUP;
      end
      ST_SETUP: if (cnt_zero) begin state_d = ST_PULSE; cnt_d = L_EN;   end
      ST_PULSE: if (cnt_zero) begin state_d = ST_HOLD;  cnt_d = L_HOLD; end
      ST_HOLD: if (cnt_zero) begin
        state_d = ST_WAIT;
        cnt_d   = is_slow_cmd(rs_q, data_q) ? L_CLR : L_WAIT;
      end
      ST_WAIT: if (cnt_zero) begin
        if (!done_q) begin
          if (idx_q == 3'(INIT_LEN - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_LOAD;
          end
        end
`ifdef LCD_LINE_WRAP_EN
        else if (pend_q) state_d = ST_LOAD;
`endif
        else state_d = ST_IDLE;
      end
      ST_IDLE: if (in_valid && in_ready) begin
        rs_d    = in_rs;
        data_d  = in_data;
        state_d = ST_SETUP;
        cnt_d   = L_SETUP;
`ifdef LCD_LINE_WRAP_EN
        if (in_rs) begin
          col_d = col_q + 5'd1;
          if (col_q == 5'd31) line1_d = 1'b1;
          if (col_q == 5'd16 || line1_q) begin
            // Strobe the address command first; the character follows via LOAD.
            rs_d    = 1'b0;
            data_d  = (col_q == 5'd16) ? LCD_CMD_LINE2 : LCD_CMD_LINE1;
            pend_d  = 1'b1;
            pdata_d = in_data;
            if (col_q != 5'd16) line1_d = 1'b0;
          end
        end else begin
          col_d   = 5'd0;
          line1_d = 1'b0;
        end
`endif
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_POWERUP;
      cnt_q   <= L_PWR;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
      col_q   <= 5'd0;
      line1_q <= 1'b0;
      pend_q  <= 1'b0;
      pdata_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= (state_d == ST_PULSE);
`ifdef LCD_LINE_WRAP_EN
      col_q   <= col_d;
      line1_q <= line1_d;
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
`endif
    end
  end

endmodule
